// File: rtl/sfq_xnort_capture.sv
// sfq_xnort_capture: turns XNOR-T gate/q toggle streams into packed result words with error flags.
module sfq_xnort_capture #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sfq_clk_tgl,
  input  logic             sfq_q_tgl,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_multi,
  output logic             err_orphan,
  output logic             err_overflow,
  input  logic             err_clr
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, ARMED} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_c, sync_q;
  logic prev_c, prev_q, started;
  logic gate_edge, q_edge;
  logic pending, pending_n, bit_v, done;
  logic [CW-1:0] count, count_n;
  logic [WIDTH-1:0] shreg, shreg_n, data_n;
  logic valid_n, multi_n, orphan_n, ovf_n;
  // First cycle after reset preloads the chains with the live level so no false edge appears.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_c  <= '0;
      sync_q  <= '0;
      prev_c  <= 1'b0;
      prev_q  <= 1'b0;
      started <= 1'b0;
    end else if (!started) begin
      sync_c  <= {SYNC_STAGES{sfq_clk_tgl}};
      sync_q  <= {SYNC_STAGES{sfq_q_tgl}};
      prev_c  <= sfq_clk_tgl;
      prev_q  <= sfq_q_tgl;
      started <= 1'b1;
    end else begin
      sync_c <= {sync_c[SYNC_STAGES-2:0], sfq_clk_tgl};
      sync_q <= {sync_q[SYNC_STAGES-2:0], sfq_q_tgl};
      prev_c <= sync_c[SYNC_STAGES-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  assign gate_edge = started & (sync_c[SYNC_STAGES-1] ^ prev_c);
  assign q_edge    = started & (sync_q[SYNC_STAGES-1] ^ prev_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      count        <= '0;
      shreg        <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      err_multi    <= 1'b0;
      err_orphan   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_n;
      pending      <= pending_n;
      count        <= count_n;
      shreg        <= shreg_n;
      out_data     <= data_n;
      out_valid    <= valid_n;
      err_multi    <= multi_n;
      err_orphan   <= orphan_n;
      err_overflow <= ovf_n;
    end
  // A q edge coincident with the closing gate edge belongs to the closing window.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    count_n   = count;
    shreg_n   = shreg;
    data_n    = out_data;
    valid_n   = out_valid & ~out_ready;
    multi_n   = err_multi & ~err_clr;
    orphan_n  = err_orphan & ~err_clr;
    ovf_n     = err_overflow & ~err_clr;
    bit_v     = pending | q_edge;
    done      = 1'b0;
    if (state == IDLE) begin
      if (gate_edge) begin
        state_n   = ARMED;
        pending_n = 1'b0;
        count_n   = '0;
      end
      if (q_edge) orphan_n = 1'b1;
    end else if (gate_edge) begin
      if (q_edge && pending) multi_n = 1'b1;
      shreg_n   = MSB_FIRST ? {shreg[WIDTH-2:0], bit_v} : {bit_v, shreg[WIDTH-1:1]};
      pending_n = 1'b0;
      done      = (count == CW'(WIDTH - 1));
      count_n   = done ? '0 : count + CW'(1);
    end else if (q_edge) begin
      if (pending) multi_n = 1'b1;
      pending_n = 1'b1;
    end
    if (done) begin
      if (!out_valid || out_ready) begin
        data_n  = shreg_n;
        valid_n = 1'b1;
      end else ovf_n = 1'b1;
    end
  end
endmodule

// File: doc/sfq_xnort_capture.md
Name: sfq_xnort_capture

Overview:
- Downstream consumer of the toggle-encoded XNOR-T cell output. Each transition (either polarity) on a toggle line represents one SFQ pulse.
- Samples the cell's gate-clock toggle line and q toggle line in the synchronous `clk` domain.
- Turns each gate-clock period into one result bit: 1 when a q pulse followed that gate pulse, i.e. the XNOR inputs were equal.
- Packs the bits into WIDTH-bit words, delivers them through a valid/ready handshake, and flags pulse-timing and overflow errors.

Parameters:
- WIDTH, 8, bits per output word (2..32).
- SYNC_STAGES, 2, synchronizer flops per toggle input (2..4).
- MSB_FIRST, 0, 0 places the first bit of a word at out_data[0]; 1 places it at out_data[WIDTH-1].

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk.
- sfq_clk_tgl  in  1  toggle-encoded gate clock that drives the XNOR-T cell; asynchronous to clk.
- sfq_q_tgl  in  1  toggle-encoded XNOR-T output q; asynchronous to clk.
- out_data  out  WIDTH  assembled word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a clk edge.
- err_multi  out  1  sticky: two or more q pulses arrived in one gate window.
- err_orphan  out  1  sticky: a q pulse arrived before the first gate pulse after reset.
- err_overflow  out  1  sticky: a completed word was dropped because out_valid was still pending.
- err_clr  in  1  synchronous clear of all three sticky error flags.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: out_data=0, out_valid=0, all err_* = 0.
  - Internal state: synchronizer chains, edge registers, pending bit, bit counter, shift register and armed flag cleared.
  - Synchronizer chains and the "previous" registers load the current input level on the first clk after release, so no spurious edge is detected.
- Edge detection:
  - Each input passes through SYNC_STAGES flops, then one "previous" flop.
  - An edge is sync_out XOR previous.
  - Latency from an input transition to the edge strobe is SYNC_STAGES+1 clk cycles.
- Window FSM, states IDLE and ARMED:
  - IDLE: a gate edge moves to ARMED and clears pending and count; no bit is produced. A q edge in IDLE sets err_orphan and is otherwise ignored.
  - ARMED, q edge with pending=0: set pending.
  - ARMED, q edge with pending=1: set err_multi; pending stays 1.
  - ARMED, gate edge: commit bit=pending to the shift register, clear pending, count+1.
  - q edge and gate edge in the same clk cycle: the q pulse belongs to the window being closed, because the cell emits q about 19 ps after its gate pulse. Commit bit = pending OR 1. If pending was already 1, set err_multi. The new window starts with pending=0.
- Word assembly:
  - When count reaches WIDTH in a commit cycle, the word is complete and count wraps to 0 in that cycle.
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: load out_data and set out_valid=1. A simultaneous handshake and load keep out_valid high with the new data.
  - Otherwise drop the word, set err_overflow, leave out_data unchanged.
  - Handshake with no new word: out_valid goes to 0 on the next edge; out_data holds its value.
- Throughput limit: gate toggles must be at least SYNC_STAGES+2 clk cycles apart, or transitions are lost. This is a documented constraint and is not detected.
- Error flags: sticky until err_clr=1 or reset. If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- Reset mid-word discards the partial word and returns to IDLE.

Test Plan:
- Reset release with sfq_clk_tgl=1 and sfq_q_tgl=1 held static → no edges, out_valid=0, all errors 0 for 20 cycles.
- WIDTH=8, MSB_FIRST=0: one arming gate pulse, then 8 windows with q pulses in windows 0,2,3,7, out_ready=1 → out_data=0x8D, out_valid high for 1 cycle.
- q toggle in the same synchronized cycle as the gate toggle that closes window 0, all other windows empty → bit0=1, out_data=0x01, err_multi=0.
- Two q toggles in one window → err_multi=1, that bit=1; err_clr pulse → err_multi=0.
- out_ready=0, 16 windows with all q pulses → first word 0xFF held, err_overflow=1. Then out_ready=1 → 0xFF accepted, out_valid=0.
- rst_n asserted after 5 bits → outputs 0 immediately. q pulse before any gate pulse → err_orphan=1. A full word afterwards assembles correctly.
